conv_window_feeder: RTL and testbench

- Upstream stage of the 9-tap pipelined MAC.
- Accepts a raster-order activation stream (one pixel per accepted beat) through two row line buffers and a 3x3 shift window.
- Presents each valid 3x3 window together with a 9-entry weight bank, in the MAC's tap order.
- Raises window_valid, which drives the MAC's input_valid; no padding, so only full windows are produced.

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_window_feeder_line_buffer.sv | 25 ++
 rtl/conv_window_feeder.sv | 176 +++++++++++++++++
 tb/tb_conv_window_feeder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the 3x3 convolution window feeder.
// Taps are flattened row-major into 9*DATA_WIDTH buses.
package conv_pkg;

  localparam int KERNEL_DIM  = 3;
  localparam int KERNEL_TAPS = KERNEL_DIM * KERNEL_DIM;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } feeder_state_t;

  // Bit position of tap k inside a flattened tap bus.
  function automatic int tap_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/conv_window_feeder_line_buffer.sv
// One image row of storage: combinational read, write on enable.
// The old word is read before the same index is overwritten.
module line_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  assign rd_data = mem_r[addr];

  // Row storage write port; contents need no reset, output is gated by counters.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_r[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Raster-order pixel stream -> 3x3 windows plus weight bank for the 9-tap MAC.
// Windows straddling a row wrap are suppressed; there is no padding.
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32
) (
  input  logic                              clk,
  input  logic                              arst_in,
  input  logic                              start,
  input  logic [DATA_WIDTH-1:0]             pixel_in,
  input  logic                              pixel_valid,
  output logic                              pixel_ready,
  input  logic                              w_load,
  input  logic [3:0]                        w_idx,
  input  logic [DATA_WIDTH-1:0]             w_data,
  output logic [KERNEL_TAPS*DATA_WIDTH-1:0] window_out,
  output logic [KERNEL_TAPS*DATA_WIDTH-1:0] weights_out,
  output logic                              window_valid,
  output logic                              window_first,
  output logic                              window_last,
  output logic                              frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  feeder_state_t                      state_r;
  logic [COL_W-1:0]                   col_r;
  logic [ROW_W-1:0]                   row_r;
  logic                               pixel_ready_r;
  logic                               window_valid_r;
  logic                               window_first_r;
  logic                               window_last_r;
  logic                               frame_done_r;
  logic [KERNEL_TAPS*DATA_WIDTH-1:0]  window_out_r;
  logic [KERNEL_TAPS*DATA_WIDTH-1:0]  weights_r;
  logic [DATA_WIDTH-1:0]              win_r     [KERNEL_TAPS];
  logic [DATA_WIDTH-1:0]              win_nxt_s [KERNEL_TAPS];
  logic [KERNEL_TAPS*DATA_WIDTH-1:0]  win_pack_s;
  logic [DATA_WIDTH-1:0]              lb1_rd_s;
  logic [DATA_WIDTH-1:0]              lb2_rd_s;
  logic                               accept_s;
  logic                               win_pos_s;
  logic                               first_pos_s;
  logic                               last_pix_s;

  assign accept_s    = pixel_valid & pixel_ready_r;
  assign win_pos_s   = (row_r >= ROW_W'(2)) && (col_r >= COL_W'(2));
  assign first_pos_s = (row_r == ROW_W'(2)) && (col_r == COL_W'(2));
  assign last_pix_s  = (row_r == ROW_LAST) && (col_r == COL_LAST);

  // lb1 holds the previous row, lb2 the row before it, both indexed by column.
  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb1 (
    .clk     (clk),
    .en      (accept_s),
    .addr    (col_r),
    .wr_data (pixel_in),
    .rd_data (lb1_rd_s)
  );

  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb2 (
    .clk     (clk),
    .en      (accept_s),
    .addr    (col_r),
    .wr_data (lb1_rd_s),
    .rd_data (lb2_rd_s)
  );

  // Next window contents: shift left one column, new right column from the row buffers.
  always_comb begin
    for (int r = 0; r < KERNEL_DIM; r++) begin
      for (int c = 0; c < KERNEL_DIM - 1; c++) begin
        win_nxt_s[r*KERNEL_DIM + c] = win_r[r*KERNEL_DIM + c + 1];
      end
    end
    win_nxt_s[KERNEL_DIM - 1]   = lb2_rd_s;
    win_nxt_s[2*KERNEL_DIM - 1] = lb1_rd_s;
    win_nxt_s[KERNEL_TAPS - 1]  = pixel_in;
  end

  // Flatten the next window into the MAC tap bus.
  always_comb begin
    win_pack_s = '0;
    for (int k = 0; k < KERNEL_TAPS; k++) begin
      win_pack_s[tap_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = win_nxt_s[k];
    end
  end

  // Frame FSM with counters, shift window and registered window outputs.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state_r        <= IDLE;
      col_r          <= '0;
      row_r          <= '0;
      pixel_ready_r  <= 1'b0;
      window_valid_r <= 1'b0;
      window_first_r <= 1'b0;
      window_last_r  <= 1'b0;
      frame_done_r   <= 1'b0;
      window_out_r   <= '0;
      for (int k = 0; k < KERNEL_TAPS; k++) begin
        win_r[k] <= '0;
      end
    end else begin
      window_valid_r <= 1'b0;
      window_first_r <= 1'b0;
      window_last_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          frame_done_r <= 1'b0;
          if (start) begin
            state_r       <= STREAM;
            pixel_ready_r <= 1'b1;
            col_r         <= '0;
            row_r         <= '0;
          end
        end
        STREAM: begin
          if (accept_s) begin
            win_r <= win_nxt_s;
            if (col_r == COL_LAST) begin
              col_r <= '0;
              row_r <= (row_r == ROW_LAST) ? '0 : row_r + ROW_W'(1);
            end else begin
              col_r <= col_r + COL_W'(1);
            end
            // Windows whose left columns belong to the previous row are dropped here.
            if (win_pos_s) begin
              window_out_r   <= win_pack_s;
              window_valid_r <= 1'b1;
              window_first_r <= first_pos_s;
              window_last_r  <= last_pix_s;
            end
            if (last_pix_s) begin
              state_r       <= DONE;
              pixel_ready_r <= 1'b0;
              frame_done_r  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_r      <= IDLE;
          frame_done_r <= 1'b0;
        end
        default: begin
          state_r       <= IDLE;
          pixel_ready_r <= 1'b0;
          frame_done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Weight bank; out-of-range indices are dropped.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      weights_r <= '0;
    end else if (w_load && (w_idx <= 4'd8)) begin
      weights_r[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH] <= w_data;
    end
  end

  assign pixel_ready  = pixel_ready_r;
  assign window_valid = window_valid_r;
  assign window_first = window_first_r;
  assign window_last  = window_last_r;
  assign frame_done   = frame_done_r;
  assign window_out   = window_out_r;
  assign weights_out  = weights_r;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench: 4x4 frames (back-to-back, gapped, aborted, start poke), weights, and a 3x3 frame.
module tb_conv_window_feeder;

  localparam int DW = 16;
  localparam int CW = 9 * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst_in, start, pixel_valid, w_load;
  logic [DW-1:0] pixel_in, w_data;
  logic [3:0]    w_idx;
  logic          pixel_ready, window_valid, window_first, window_last, frame_done;
  logic [CW-1:0] window_out, weights_out;

  logic          s3_start, s3_pixel_valid;
  logic [DW-1:0] s3_pixel_in;
  logic          s3_pixel_ready, s3_window_valid, s3_window_first, s3_window_last, s3_frame_done;
  logic [CW-1:0] s3_window_out, s3_weights_out;

  int n_cmp = 0;
  int n_err = 0;

  conv_window_feeder #(.DATA_WIDTH(DW), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .arst_in(arst_in), .start(start), .pixel_in(pixel_in),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .w_load(w_load),
    .w_idx(w_idx), .w_data(w_data), .window_out(window_out),
    .weights_out(weights_out), .window_valid(window_valid),
    .window_first(window_first), .window_last(window_last), .frame_done(frame_done)
  );

  conv_window_feeder #(.DATA_WIDTH(DW), .IMG_W(3), .IMG_H(3)) dut3 (
    .clk(clk), .arst_in(arst_in), .start(s3_start), .pixel_in(s3_pixel_in),
    .pixel_valid(s3_pixel_valid), .pixel_ready(s3_pixel_ready), .w_load(1'b0),
    .w_idx(4'd0), .w_data(16'd0), .window_out(s3_window_out),
    .weights_out(s3_weights_out), .window_valid(s3_window_valid),
    .window_first(s3_window_first), .window_last(s3_window_last), .frame_done(s3_frame_done)
  );

  task automatic check_vec(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Window ending at pixel (r,c) of a w-wide image whose pixel values are w*row+col+off.
  function automatic logic [CW-1:0] exp_win(input int w, input int r, input int c, input int off);
    logic [CW-1:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) begin
      v[k*DW +: DW] = DW'(w * (r - 2 + k / 3) + (c - 2 + k % 3) + off);
    end
    return v;
  endfunction

  task automatic start4();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_bit("ready_after_start", pixel_ready, 1'b1);
  endtask

  // Stream a 4x4 frame; optional gaps after every 2nd pixel, early stop, and a start poke.
  task automatic stream4(input int gap_len, input int off, input int stop_after, input int poke_at);
    int wins;
    int r, c;
    logic exp_v;
    wins = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == stop_after) return;
      r = i / 4;
      c = i % 4;
      pixel_in    = DW'(i + off);
      pixel_valid = 1'b1;
      start       = (i == poke_at);
      @(posedge clk); #1;
      start = 1'b0;
      exp_v = (r >= 2) && (c >= 2);
      check_bit("win_valid", window_valid, exp_v);
      check_bit("win_first", window_first, (r == 2) && (c == 2));
      check_bit("win_last", window_last, (r == 3) && (c == 3));
      check_bit("frame_done", frame_done, i == 15);
      if (exp_v) begin
        wins++;
        check_vec("win_data", window_out, exp_win(4, r, c, off));
      end
      if (gap_len > 0 && (i % 2) == 1 && i != 15) begin
        pixel_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          @(posedge clk); #1;
          check_bit("gap_no_win", window_valid, 1'b0);
        end
      end
    end
    check_vec("win_count", CW'(wins), CW'(4));
    check_bit("ready_in_done", pixel_ready, 1'b0);
    @(posedge clk); #1;
    check_bit("no_win_after_done", window_valid, 1'b0);
    check_bit("done_one_cycle", frame_done, 1'b0);
    check_bit("ready_in_idle", pixel_ready, 1'b0);
    pixel_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_in = 1'b1; start = 1'b0; pixel_valid = 1'b0; pixel_in = '0;
    w_load = 1'b0; w_idx = 4'd0; w_data = '0;
    s3_start = 1'b0; s3_pixel_valid = 1'b0; s3_pixel_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("rst_ready", pixel_ready, 1'b0);
    check_bit("rst_valid", window_valid, 1'b0);
    check_bit("rst_done", frame_done, 1'b0);
    check_vec("rst_window", window_out, '0);
    check_vec("rst_weights", weights_out, '0);
    arst_in = 1'b0;

    // IDLE must not accept even with pixel_valid high
    pixel_valid = 1'b1;
    @(posedge clk); #1;
    check_bit("idle_not_ready", pixel_ready, 1'b0);
    check_bit("idle_no_win", window_valid, 1'b0);
    pixel_valid = 1'b0;

    start4();
    stream4(0, 0, 99, -1);

    start4();
    stream4(3, 0, 99, -1);

    for (int i = 0; i < 9; i++) begin
      w_load = 1'b1; w_idx = 4'(i); w_data = DW'(i + 1);
      @(posedge clk); #1;
    end
    w_load = 1'b1; w_idx = 4'd12; w_data = 16'd99;
    @(posedge clk); #1;
    w_load = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check_vec("weight_tap", CW'(weights_out[k*DW +: DW]), CW'(k + 1));
    end

    // Abort a frame of offset values mid-way, then a clean frame must not see them
    start4();
    stream4(0, 100, 7, -1);
    pixel_valid = 1'b0;
    arst_in = 1'b1;
    #2;
    check_bit("abort_ready", pixel_ready, 1'b0);
    check_vec("abort_window", window_out, '0);
    check_vec("abort_weights", weights_out, '0);
    @(posedge clk); #1;
    check_bit("abort_valid", window_valid, 1'b0);
    check_bit("abort_done", frame_done, 1'b0);
    arst_in = 1'b0;
    start4();
    stream4(0, 0, 99, -1);

    start4();
    stream4(0, 0, 99, 5);

    // 3x3 image: exactly one window, first and last together
    s3_start = 1'b1;
    @(posedge clk); #1;
    s3_start = 1'b0;
    check_bit("s3_ready", s3_pixel_ready, 1'b1);
    for (int i = 0; i < 9; i++) begin
      s3_pixel_in = DW'(i); s3_pixel_valid = 1'b1;
      @(posedge clk); #1;
      check_bit("s3_valid", s3_window_valid, i == 8);
      check_bit("s3_done", s3_frame_done, i == 8);
    end
    s3_pixel_valid = 1'b0;
    check_vec("s3_window", s3_window_out, exp_win(3, 2, 2, 0));
    check_bit("s3_first", s3_window_first, 1'b1);
    check_bit("s3_last", s3_window_last, 1'b1);
    check_vec("s3_weights", s3_weights_out, '0);
    @(posedge clk); #1;
    check_bit("s3_one_win", s3_window_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
